// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: widths, opcodes and reset polarity for the
// instruction-decode operand stage.
package mips_pkg;

   localparam int   DATA_W       = 32;
   localparam int   REG_ADDR_W   = 5;
   localparam int   STALL_W      = 16;
   localparam logic RESET_ACTIVE = 1'b0;

   typedef enum logic [5:0] {
      OPC_RTYPE = 6'h00,
      OPC_ANDI  = 6'h0C,
      OPC_ORI   = 6'h0D,
      OPC_XORI  = 6'h0E,
      OPC_LW    = 6'h23
   } opcode_e;

   // Logical immediates are unsigned; every other I-type sign-extends.
   function automatic logic imm_is_unsigned(input logic [5:0] opcode);
      return (opcode == OPC_ANDI) || (opcode == OPC_ORI) || (opcode == OPC_XORI);
   endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// IF/ID input, register-file ports, EX/MEM results and ID/EX output of the
// operand stage. slave = the stage itself, master = its surroundings.
interface id_operand_stage_if
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_W,
   parameter int REG_ADDR_WIDTH = REG_ADDR_W
) ();

   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     in_pc;
   logic [DATA_WIDTH-1:0]     in_inst;

   logic                      read_enable_a;
   logic [REG_ADDR_WIDTH-1:0] read_address_a;
   logic [DATA_WIDTH-1:0]     read_data_a;
   logic                      read_enable_b;
   logic [REG_ADDR_WIDTH-1:0] read_address_b;
   logic [DATA_WIDTH-1:0]     read_data_b;

   logic                      ex_write_enable;
   logic [REG_ADDR_WIDTH-1:0] ex_write_address;
   logic [DATA_WIDTH-1:0]     ex_write_data;
   logic                      ex_is_load;
   logic                      mem_write_enable;
   logic [REG_ADDR_WIDTH-1:0] mem_write_address;
   logic [DATA_WIDTH-1:0]     mem_write_data;

   logic                      flush;

   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_WIDTH-1:0]     out_pc;
   logic [5:0]                out_opcode;
   logic [5:0]                out_funct;
   logic [DATA_WIDTH-1:0]     out_operand_a;
   logic [DATA_WIDTH-1:0]     out_operand_b;
   logic [DATA_WIDTH-1:0]     out_imm;
   logic [REG_ADDR_WIDTH-1:0] out_dest;
   logic [STALL_W-1:0]        stall_count;

   modport slave (
      input  in_valid, in_pc, in_inst, read_data_a, read_data_b,
             ex_write_enable, ex_write_address, ex_write_data, ex_is_load,
             mem_write_enable, mem_write_address, mem_write_data, flush, out_ready,
      output in_ready, read_enable_a, read_address_a, read_enable_b, read_address_b,
             out_valid, out_pc, out_opcode, out_funct, out_operand_a, out_operand_b,
             out_imm, out_dest, stall_count
   );

   modport master (
      output in_valid, in_pc, in_inst, read_data_a, read_data_b,
             ex_write_enable, ex_write_address, ex_write_data, ex_is_load,
             mem_write_enable, mem_write_address, mem_write_data, flush, out_ready,
      input  in_ready, read_enable_a, read_address_a, read_enable_b, read_address_b,
             out_valid, out_pc, out_opcode, out_funct, out_operand_a, out_operand_b,
             out_imm, out_dest, stall_count
   );

endinterface

// File: rtl/operand_forward.sv
// Source select and hazard flag for one source operand.
// ID_FORWARD_EN defined: EX/MEM bypass with load-use stall; otherwise any EX/MEM match stalls.
module operand_forward
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_W,
   parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
   input  logic [REG_ADDR_WIDTH-1:0] src_addr,
   input  logic [DATA_WIDTH-1:0]     rf_data,
   input  logic                      ex_write_enable,
   input  logic [REG_ADDR_WIDTH-1:0] ex_write_address,
   input  logic [DATA_WIDTH-1:0]     ex_write_data,
   input  logic                      ex_is_load,
   input  logic                      mem_write_enable,
   input  logic [REG_ADDR_WIDTH-1:0] mem_write_address,
   input  logic [DATA_WIDTH-1:0]     mem_write_data,
   output logic [DATA_WIDTH-1:0]     operand,
   output logic                      hazard
);

   logic src_nonzero;
   logic ex_match;
   logic mem_match;

   // r0 is hardwired: it never matches a producer, so it never forwards or stalls.
   assign src_nonzero = (src_addr != '0);
   assign ex_match    = ex_write_enable  && src_nonzero && (ex_write_address  == src_addr);
   assign mem_match   = mem_write_enable && src_nonzero && (mem_write_address == src_addr);

`ifdef ID_FORWARD_EN
   // NOTE: give every always_comb output a default first so no path infers a latch.
   always_comb begin
      operand = rf_data;
      if (!src_nonzero)
         operand = '0;
      else if (ex_match && !ex_is_load)
         operand = ex_write_data;
      else if (mem_match)
         operand = mem_write_data;
   end

   assign hazard = ex_match && ex_is_load;
`else
   logic unused_bypass;
   assign unused_bypass = ^{ex_write_data, mem_write_data, ex_is_load};

   assign operand = src_nonzero ? rf_data : '0;
   assign hazard  = ex_match || mem_match;
`endif

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: decodes rs/rt/rd/imm, selects operands, registers the ID/EX payload.
// Forwarding is compiled in with ID_FORWARD_EN (see operand_forward).
module id_operand_stage
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_W,
   parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
   input logic               clk,
   input logic               rst_n,
   id_operand_stage_if.slave bus
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]     pc;
      logic [5:0]                opcode;
      logic [5:0]                funct;
      logic [DATA_WIDTH-1:0]     operand_a;
      logic [DATA_WIDTH-1:0]     operand_b;
      logic [DATA_WIDTH-1:0]     imm;
      logic [REG_ADDR_WIDTH-1:0] dest;
   } id_ex_t;

   logic [5:0]                opcode;
   logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
   logic [DATA_WIDTH-1:0]     operand_a, operand_b;
   logic                      hazard_a, hazard_b, hazard;
   logic                      rst_released, out_free;
   id_ex_t                    decoded;

   id_ex_t             payload_q, payload_d;
   logic               out_valid_q, out_valid_d;
   logic [STALL_W-1:0] stall_count_q, stall_count_d;

   assign opcode = bus.in_inst[31:26];
   assign rs     = bus.in_inst[21 +: REG_ADDR_WIDTH];
   assign rt     = bus.in_inst[16 +: REG_ADDR_WIDTH];
   assign rd     = bus.in_inst[11 +: REG_ADDR_WIDTH];

   assign rst_released       = (rst_n != RESET_ACTIVE);
   assign bus.read_address_a = rs;
   assign bus.read_address_b = rt;
   assign bus.read_enable_a  = bus.in_valid && rst_released;
   assign bus.read_enable_b  = bus.in_valid && rst_released;

   operand_forward #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
      .src_addr(rs), .rf_data(bus.read_data_a),
      .ex_write_enable(bus.ex_write_enable), .ex_write_address(bus.ex_write_address),
      .ex_write_data(bus.ex_write_data), .ex_is_load(bus.ex_is_load),
      .mem_write_enable(bus.mem_write_enable), .mem_write_address(bus.mem_write_address),
      .mem_write_data(bus.mem_write_data), .operand(operand_a), .hazard(hazard_a)
   );

   operand_forward #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
      .src_addr(rt), .rf_data(bus.read_data_b),
      .ex_write_enable(bus.ex_write_enable), .ex_write_address(bus.ex_write_address),
      .ex_write_data(bus.ex_write_data), .ex_is_load(bus.ex_is_load),
      .mem_write_enable(bus.mem_write_enable), .mem_write_address(bus.mem_write_address),
      .mem_write_data(bus.mem_write_data), .operand(operand_b), .hazard(hazard_b)
   );

   assign hazard       = hazard_a || hazard_b;
   assign out_free     = !out_valid_q || bus.out_ready;
   // Flush always drains the input, whatever the hazard or backpressure state.
   assign bus.in_ready = rst_released && (bus.flush || (!hazard && out_free));

   always_comb begin
      decoded.pc        = bus.in_pc;
      decoded.opcode    = opcode;
      decoded.funct     = bus.in_inst[5:0];
      decoded.operand_a = operand_a;
      decoded.operand_b = operand_b;
      decoded.imm       = imm_is_unsigned(opcode)
                        ? {{(DATA_WIDTH-16){1'b0}}, bus.in_inst[15:0]}
                        : {{(DATA_WIDTH-16){bus.in_inst[15]}}, bus.in_inst[15:0]};
      decoded.dest      = (opcode == OPC_RTYPE) ? rd : rt;
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      payload_d     = payload_q;
      stall_count_d = stall_count_q;

      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (out_free) begin
         out_valid_d = bus.in_valid && !hazard;
         if (bus.in_valid && !hazard)
            payload_d = decoded;
      end

      if (bus.in_valid && hazard && (stall_count_q != '1))
         stall_count_d = stall_count_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n == RESET_ACTIVE) begin
         out_valid_q   <= 1'b0;
         payload_q     <= '0;
         stall_count_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         payload_q     <= payload_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_pc        = payload_q.pc;
   assign bus.out_opcode    = payload_q.opcode;
   assign bus.out_funct     = payload_q.funct;
   assign bus.out_operand_a = payload_q.operand_a;
   assign bus.out_operand_b = payload_q.operand_b;
   assign bus.out_imm       = payload_q.imm;
   assign bus.out_dest      = payload_q.dest;
   assign bus.stall_count   = stall_count_q;

endmodule

// File: doc/id_operand_stage.md
ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand/instruction/PC width.
REQ-002 Parameter REG_ADDR_WIDTH, 5, register index width.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-005 in_valid / in_ready / in_pc / in_inst  in/out/in/in  1/1/32/32  IF/ID handshake and payload.
REQ-006 read_enable_a / read_address_a / read_data_a  out/out/in  1/5/32  register-file port A, rs.
REQ-007 read_enable_b / read_address_b / read_data_b  out/out/in  1/5/32  register-file port B, rt.
REQ-008 ex_write_enable / ex_write_address / ex_write_data / ex_is_load  in  1/5/32/1  EX-stage result.
REQ-009 mem_write_enable / mem_write_address / mem_write_data  in  1/5/32  MEM-stage result.
REQ-010 flush  in  1  squash accepted and held instruction.
REQ-011 out_valid / out_ready  out/in  1/1  ID/EX handshake.
REQ-012 out_pc 32, out_opcode 6, out_funct 6, out_operand_a 32, out_operand_b 32, out_imm 32, out_dest 5  out  registered ID/EX payload.
REQ-013 stall_count  out  16  saturating count of hazard-stall cycles.

Function
REQ-014 rs = in_inst[25:21], rt = in_inst[20:16]; read_address_a = rs, read_address_b = rt, both combinational; read enables = in_valid while reset deasserted.
REQ-015 out_dest = rd (in_inst[15:11]) when opcode 0; rt otherwise.
REQ-016 out_imm zero-extends in_inst[15:0] for opcodes 0x0C/0x0D/0x0E; sign-extends for all others.
REQ-017 Operand source priority per operand: EX result if ex_write_enable, address match, address != 0, not ex_is_load; else MEM result on same conditions; else register-file read data.
REQ-018 Register index 0 never forwarded, never triggers a hazard; operand reads as 0.
REQ-019 Writeback-stage values come through the register-file read port (file writes on negedge); no WB forwarding path.
REQ-020 Load-use hazard: ex_is_load && ex_write_enable && ex_write_address != 0 && equals rs or rt.
REQ-021 in_ready = !hazard && (!out_valid || out_ready), or 1 when flush is high.
REQ-022 Accept on in_valid && in_ready: payload latched next posedge, out_valid = 1; latency exactly one cycle.
REQ-023 out_valid && !out_ready: all outputs hold unchanged.
REQ-024 Hazard with output free or consumed: out_valid = 0 next cycle (bubble), instruction stays at input.
REQ-025 flush: out_valid = 0 next posedge; same-cycle input consumed and discarded; flush beats hazard and accept.
REQ-026 stall_count increments each cycle in_valid && hazard, saturates at 0xFFFF.

Reset
REQ-027 reset low: out_valid, all out_* payloads, stall_count = 0 immediately; read enables = 0; in_ready = 0.
REQ-028 Reset mid-transfer drops the held instruction; operation resumes on first posedge after release.

Configuration
REQ-029 Macro ID_FORWARD_EN: defined -> REQ-017 forwarding active.
REQ-030 Undefined: no bypass; hazard = any EX or MEM write-enabled match of nonzero rs/rt; operands only from register file.

Structure
REQ-031 Shared package mips_pkg: width constants, opcode constants (R-type, ANDI, ORI, XORI, LW), reset-polarity constant.
REQ-032 Sub-module operand_forward: one operand's select logic plus hazard flag, instantiated twice.

Verification
REQ-033 R-type ADD rs=1, rt=2, rd=3, file r1=5, r2=7, no forwarding -> one cycle later out_valid=1, operands 5/7, out_dest=3.
REQ-034 EX writes r1=0xAA, MEM writes r1=0xBB, rs=1 -> operand_a=0xAA (EX wins); without ID_FORWARD_EN -> bubble, stall_count increments.
REQ-035 ex_is_load to r2, next instruction rt=2 -> in_ready=0 one cycle, bubble out, stall_count=1, instruction issues next cycle.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> next instruction issues.
REQ-037 ORI imm 0x8000 -> out_imm 0x00008000; ADDI imm 0x8000 -> 0xFFFF8000; rs=0 with EX write r0 -> operand 0.
REQ-038 flush with valid held instruction -> out_valid=0 next cycle; reset asserted mid-stall -> all outputs 0 immediately.
